// File: rtl/tu_ptr_interp_mc.sv
// Time-multiplexed TU/AU pointer interpreter: NCH channels share one evaluation datapath,
// per-channel state is held in arrays and read-modify-written on each V2/H2 byte.
module tu_ptr_interp_mc #(
    parameter int          NCH       = 21,
    parameter int          CHW       = 5,
    parameter int          MAXOFFSET = 139,
    parameter int          NINV      = 8,
    parameter int          NNDF      = 8,
    parameter int          HOLDOFF   = 3,
    parameter bit          SS_CHK    = 1'b0,
    parameter logic [1:0]  SS_VAL    = 2'b10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ptr_vld,
    input  logic [CHW-1:0] ptr_ch,
    input  logic           ptr_sel,
    input  logic [7:0]     ptr_byte,
    output logic           out_vld,
    output logic [CHW-1:0] out_ch,
    output logic [9:0]     out_offset,
    output logic           out_inc,
    output logic           out_dec,
    output logic           out_ndf,
    output logic [NCH-1:0] lop_vec,
    output logic [NCH-1:0] ais_vec
);

    typedef enum logic [1:0] {ST_NORM = 2'd0, ST_LOP = 2'd1, ST_AIS = 2'd2} st_t;
    typedef enum logic [2:0] {EV_AIS, EV_NDF, EV_INC, EV_DEC, EV_NORM, EV_NEW, EV_INV} ev_t;

    localparam logic [9:0] MAXO = 10'(MAXOFFSET);
    localparam logic [7:0] HOLD = 8'(HOLDOFF);

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [2:0] ones5(input logic [4:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic [9:0] wrap_inc(input logic [9:0] o);
        return (o >= MAXO) ? 10'd0 : o + 10'd1;
    endfunction

    function automatic logic [9:0] wrap_dec(input logic [9:0] o);
        return (o == 10'd0) ? MAXO : o - 10'd1;
    endfunction

    st_t            st_q      [NCH];
    logic [9:0]     off_q     [NCH];
    logic [9:0]     cand_q    [NCH];
    logic [7:0]     v1_q      [NCH];
    logic [7:0]     hold_q    [NCH];
    logic [7:0]     cnt_inv_q [NCH];
    logic [7:0]     cnt_ndf_q [NCH];
    logic [7:0]     cnt_new_q [NCH];
    logic [7:0]     cnt_ais_q [NCH];
    logic [NCH-1:0] v1_seen_q;

    logic           ch_ok, byte_ok, eval_p0;
    logic [CHW-1:0] idx;
    logic [7:0]     v1;
    logic [9:0]     p, x;
    logic [2:0]     i_cnt, d_cnt;
    logic           ndf_norm, ndf_en, inrange;
    ev_t            ev;

    st_t            st_n;
    logic [9:0]     off_n, cand_n;
    logic [7:0]     hold_n, inv_n, ndfc_n, new_n, ais_n;
    logic           inc_s, dec_s, ndf_s;

    assign ch_ok   = int'(ptr_ch) < NCH;
    assign byte_ok = ptr_vld && ch_ok;
    assign eval_p0 = byte_ok && ptr_sel;
    assign idx     = ch_ok ? ptr_ch : '0;

    // Stage 0: decode the pointer pair against the channel's stored offset
    assign v1       = v1_q[idx];
    assign p        = {v1[1:0], ptr_byte};
    assign x        = p ^ off_q[idx];
    assign i_cnt    = ones5({x[9], x[7], x[5], x[3], x[1]});
    assign d_cnt    = ones5({x[8], x[6], x[4], x[2], x[0]});
    assign ndf_norm = ones4(~(v1[7:4] ^ 4'b0110)) >= 3'd3;
    assign ndf_en   = ones4(~(v1[7:4] ^ 4'b1001)) >= 3'd3;
    assign inrange  = (p <= MAXO) && (!SS_CHK || (v1[3:2] == SS_VAL));

    always_comb begin
        ev = EV_INV;
        if (!v1_seen_q[idx])
            ev = EV_INV;
        else if ({v1, ptr_byte} == 16'hFFFF)
            ev = EV_AIS;
        else if (ndf_en && inrange)
            ev = EV_NDF;
        else if (ndf_norm && i_cnt >= 3'd3 && d_cnt <= 3'd2 && hold_q[idx] == 8'd0 && st_q[idx] == ST_NORM)
            ev = EV_INC;
        else if (ndf_norm && d_cnt >= 3'd3 && i_cnt <= 3'd2 && hold_q[idx] == 8'd0 && st_q[idx] == ST_NORM)
            ev = EV_DEC;
        else if (ndf_norm && inrange)
            ev = (p == off_q[idx]) ? EV_NORM : EV_NEW;
    end

    // Next-state for the channel under evaluation
    always_comb begin
        st_n   = st_q[idx];
        off_n  = off_q[idx];
        cand_n = cand_q[idx];
        hold_n = (hold_q[idx] != 8'd0) ? hold_q[idx] - 8'd1 : 8'd0;
        inv_n  = cnt_inv_q[idx];
        ndfc_n = cnt_ndf_q[idx];
        new_n  = cnt_new_q[idx];
        ais_n  = cnt_ais_q[idx];
        case (ev)
            EV_AIS: begin
                ais_n  = sat_inc(cnt_ais_q[idx]);
                inv_n  = 8'd0;
                ndfc_n = 8'd0;
                new_n  = 8'd0;
                if (ais_n >= 8'd3)
                    st_n = ST_AIS;
            end
            EV_NDF: begin
                ndfc_n = sat_inc(cnt_ndf_q[idx]);
                inv_n  = 8'd0;
                new_n  = 8'd0;
                ais_n  = 8'd0;
                if (st_q[idx] == ST_AIS) begin
                    st_n   = ST_NORM;
                    off_n  = p;
                    hold_n = HOLD;
                end else if (st_q[idx] == ST_NORM) begin
                    off_n  = p;
                    hold_n = HOLD;
                    if (ndfc_n >= 8'(NNDF))
                        st_n = ST_LOP;
                end
            end
            EV_INC, EV_DEC: begin
                inv_n  = 8'd0;
                ndfc_n = 8'd0;
                new_n  = 8'd0;
                ais_n  = 8'd0;
                off_n  = (ev == EV_INC) ? wrap_inc(off_q[idx]) : wrap_dec(off_q[idx]);
                hold_n = HOLD;
            end
            EV_NORM, EV_NEW: begin
                inv_n  = 8'd0;
                ndfc_n = 8'd0;
                ais_n  = 8'd0;
                if (st_q[idx] == ST_NORM && ev == EV_NORM) begin
                    new_n = 8'd0;
                end else begin
                    if (p == cand_q[idx]) begin
                        new_n = sat_inc(cnt_new_q[idx]);
                    end else begin
                        cand_n = p;
                        new_n  = 8'd1;
                    end
                    // Third identical pointer: adopt it and (re)enter NORM
                    if (new_n >= 8'd3) begin
                        off_n = p;
                        st_n  = ST_NORM;
                        new_n = 8'd0;
                    end
                end
            end
            default: begin
                inv_n = sat_inc(cnt_inv_q[idx]);
                ais_n = 8'd0;
                new_n = 8'd0;
                if (st_q[idx] != ST_LOP && inv_n >= 8'(NINV))
                    st_n = ST_LOP;
            end
        endcase
    end

    always_comb begin
        inc_s = eval_p0 && (ev == EV_INC);
        dec_s = eval_p0 && (ev == EV_DEC);
        ndf_s = eval_p0 && (ev == EV_NDF) && (st_n == ST_NORM);
    end

    // Stage 1: commit channel state and register the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]      <= ST_LOP;
                off_q[i]     <= 10'd0;
                hold_q[i]    <= 8'd0;
                cnt_inv_q[i] <= 8'd0;
                cnt_ndf_q[i] <= 8'd0;
                cnt_new_q[i] <= 8'd0;
                cnt_ais_q[i] <= 8'd0;
            end
            v1_seen_q  <= '0;
            out_vld    <= 1'b0;
            out_ch     <= '0;
            out_offset <= 10'd0;
            out_inc    <= 1'b0;
            out_dec    <= 1'b0;
            out_ndf    <= 1'b0;
        end else begin
            out_vld <= eval_p0;
            out_inc <= inc_s;
            out_dec <= dec_s;
            out_ndf <= ndf_s;
            if (byte_ok && !ptr_sel)
                v1_seen_q[idx] <= 1'b1;
            if (eval_p0) begin
                out_ch         <= ptr_ch;
                out_offset     <= off_n;
                st_q[idx]      <= st_n;
                off_q[idx]     <= off_n;
                hold_q[idx]    <= hold_n;
                cnt_inv_q[idx] <= inv_n;
                cnt_ndf_q[idx] <= ndfc_n;
                cnt_new_q[idx] <= new_n;
                cnt_ais_q[idx] <= ais_n;
                v1_seen_q[idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byte_ok && !ptr_sel)
            v1_q[idx] <= ptr_byte;
        if (eval_p0)
            cand_q[idx] <= cand_n;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_alarm
        assign lop_vec[g] = (st_q[g] == ST_LOP);
        assign ais_vec[g] = (st_q[g] == ST_AIS);
    end

endmodule

// File: doc/tu_ptr_interp_mc.md
Name: tu_ptr_interp_mc

Overview:
- Time-multiplexed TU/AU pointer interpreter serving NCH tributary channels with one shared evaluation datapath.
- Per-channel state lives in register arrays indexed by channel number.
- Receives V1/V2 (or H1/H2) pointer bytes tagged with a channel number from the RX demux. For each channel it produces the active payload offset, inc/dec/NDF event strobes, and LOP/AIS alarms to the downstream payload extractor and alarm block.
- Generalises the single-channel TU-12 interpreter with:
  - parametrised channel count and offset range;
  - majority NDF and I/D decoding;
  - new-pointer 3-frame confirmation;
  - inc/dec hold-off;
  - offset wrap-around.

Parameters:
- NCH, 21, number of channels (1..64).
- CHW, 5, channel index width, ceil(log2(NCH)).
- MAXOFFSET, 139, largest legal offset (TU-12 139, TU-11 103, TU-3/AU-4 764/782).
- NINV, 8, consecutive inv_point events that force LOP.
- NNDF, 8, consecutive ndf_enable events that force LOP.
- HOLDOFF, 3, evaluations after an adjustment during which inc/dec is not accepted.
- SS_CHK, 0, 1 = size bits (V1[3:2]) must equal SS_VAL or the pointer is invalid.
- SS_VAL, 2'b10, expected size bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ptr_vld  in  1  pointer byte valid.
- ptr_ch  in  CHW  channel of the byte.
- ptr_sel  in  1  0 = first byte (V1/H1), 1 = second byte (V2/H2).
- ptr_byte  in  8  pointer byte.
- out_vld  out  1  evaluation result valid (one-cycle strobe).
- out_ch  out  CHW  channel of the result.
- out_offset  out  10  active offset of out_ch after the update.
- out_inc  out  1  increment accepted.
- out_dec  out  1  decrement accepted.
- out_ndf  out  1  NDF jump accepted.
- lop_vec  out  NCH  per-channel LOP alarm.
- ais_vec  out  NCH  per-channel AIS alarm.

Behaviour:
- Reset (async, rst=1):
  - every channel: state=LOP, offset=0, all counters 0, v1_seen=0;
  - outputs: out_* = 0, lop_vec all ones, ais_vec = 0.
- Byte input rules:
  - ptr_ch >= NCH: byte ignored.
  - ptr_sel=0: store byte in v1[ch], set v1_seen[ch].
  - ptr_sel=1: triggers evaluation of ch, then clears v1_seen[ch].
  - ptr_sel=1 with v1_seen[ch]=0: classified inv_point.
  - A second V1 overwrites the first.
- Latency: out_* registered one cycle after the V2 byte.
- Per-channel state is read-modify-written in that same cycle, so back-to-back evaluations of the same channel see updated state.
- Decode: P = {v1[1:0], v2}; NDF = v1[7:4].
  - ndf_norm: >=3 bits of NDF match 0110.
  - ndf_en: >=3 bits match 1001.
  - inrange: P <= MAXOFFSET, and size bits OK when SS_CHK=1.
  - X = P xor active offset; I bits = X[9,7,5,3,1]; D bits = X[8,6,4,2,0].
- Classification, priority first to last:
  - ais_ind: {v1, v2} = 16'hFFFF.
  - ndf_enable: ndf_en & inrange.
  - inc_ind: ndf_norm, >=3 I bits inverted, <=2 D bits inverted, hold=0, state=NORM.
  - dec_ind: same with I and D swapped.
  - norm_point: ndf_norm & inrange & P = active offset.
  - new_point: ndf_norm & inrange & P != active offset.
  - inv_point: everything else.
- Each evaluation: decrement hold if nonzero.
- Any event resets the consecutive counters of the other categories:
  - ais_ind resets cnt_inv, cnt_ndf, cnt_new;
  - inv_point resets cnt_ais, cnt_new;
  - and so on for the remaining categories.
- All counters saturate.
- State NORM:
  - norm_point: stay.
  - inc_ind: offset = offset + 1, wrapping MAXOFFSET to 0; out_inc=1; hold=HOLDOFF.
  - dec_ind: offset = offset - 1, wrapping 0 to MAXOFFSET; out_dec=1; hold=HOLDOFF.
  - ndf_enable: offset = P; out_ndf=1; hold=HOLDOFF; cnt_ndf+1; reaching NNDF goes to LOP.
  - new_point: if P = cand, cnt_new+1, else cand=P and cnt_new=1; cnt_new reaching 3 loads offset=cand, no strobe.
  - ais_ind x3 consecutive: go to AIS.
  - inv_point: cnt_inv+1; reaching NINV goes to LOP.
- State LOP:
  - norm_point or new_point: candidate counting as above; 3 identical values go to NORM with offset=cand.
  - ais_ind x3 consecutive: go to AIS.
  - Others: stay.
- State AIS:
  - ndf_enable: go to NORM at once with offset=P; out_ndf=1; hold=HOLDOFF.
  - 3 identical norm_point/new_point: go to NORM.
  - inv_point x NINV consecutive: go to LOP.
  - ais_ind: stay.
- Offset during non-NORM states:
  - out_offset reports the stored offset;
  - on any entry to NORM the offset is replaced by the confirmed value.
- Alarm vectors: lop_vec[ch] = (state == LOP), ais_vec[ch] = (state == AIS), updated in the same cycle as out_vld.
- Mid-frame reset: all channels return to reset values immediately; an in-flight evaluation is discarded (out_vld=0).

Test Plan:
- Reset; channel 3 gets 3x (V1=0x68, V2=0x2A) -> offset 0x02A confirmed. lop_vec[3] clears on the 3rd out_vld, with out_offset=42 and no strobes.
- Channel 3 in NORM at offset 42, V1/V2 with I bits inverted (P = 42 xor 0x2AA) -> out_inc=1, offset 43. An inc in the next 3 evaluations of channel 3 is not accepted (no offset change, no strobe). An inc on the 4th evaluation is accepted.
- Channel 0 at offset 139, inc_ind -> offset 0. Then dec_ind after hold-off -> offset 139 (wrap both ways).
- Channel 7 in NORM, 3x {FF, FF} -> ais_vec[7]=1. Then V1=0x98, V2=0x10 -> NORM, out_ndf=1, offset 16.
- Channel 5 in NORM, 8 consecutive V2-only events (no V1) -> lop_vec[5] set on the 8th. Channel 6 interleaved with valid pointers is unaffected.
- ptr_ch=21 bytes -> no out_vld. Assert rst mid-sequence -> all lop_vec=1 and out_vld stays 0 that cycle.
